// File: rtl/io_mem_arbiter_pkg.sv
// Shared types and defaults for the IO memory arbiter (CPU IO path vs loader port).
package io_mem_arbiter_pkg;

  // Arbiter states, 2-bit encoding.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_DRAIN = 2'b01,
    ST_GRANT = 2'b10,
    ST_COOL  = 2'b11
  } arb_state_e;

  // Default parameter values.
  localparam int DEF_ADDR_W    = 8;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_HALT_LAT  = 3;
  localparam int DEF_MAX_BURST = 16;
  localparam int DEF_CPU_MIN   = 4;

  // Counter width: one bit of headroom above the largest count any state needs.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/io_mem_arbiter_down_counter.sv
// Loadable down-counter with zero flag; times the DRAIN and COOL phases.
module io_mem_arbiter_down_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         n_reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  assign zero = (count == '0);

  // Load has priority; decrement stops at zero so the count never wraps.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && !zero) begin
      count <= count - W'(1);
    end
  end

endmodule

// File: rtl/io_mem_arbiter.sv
// Arbitrates testmem between the CPU IO path and a loader port, halting the CPU while
// the loader owns the memory. Loader bursts are bounded and followed by a CPU run window.
module io_mem_arbiter
  import io_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int HALT_LAT  = DEF_HALT_LAT,
  parameter int MAX_BURST = DEF_MAX_BURST,
  parameter int CPU_MIN   = DEF_CPU_MIN
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              ext_n_halt,
  output logic              cpu_n_halt,
  input  logic              cpu_wren,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              ld_req,
  output logic              ld_gnt,
  input  logic              ld_stb,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              ld_rvalid,
  output logic              conflict,
  output logic              mem_wren,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int              CNT_W      = cnt_width(HALT_LAT, MAX_BURST, CPU_MIN);
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(HALT_LAT - 1);
  localparam logic [CNT_W-1:0] COOL_LOAD  = CNT_W'(CPU_MIN - 1);
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

  arb_state_e        state, state_next;
  logic [CNT_W-1:0]  burst_cnt, burst_next;
  logic              cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0]  cnt_val;
  logic              arb_hold;
  logic              ld_acc, rd_acc;
  logic              rd_pend;
  logic [DATA_W-1:0] rdata_hold;

  // A loader strobe is only accepted while the loader owns the memory.
  assign ld_acc   = (state == ST_GRANT) && ld_req && ld_stb;
  assign rd_acc   = ld_acc && !ld_we;
  assign arb_hold = (state == ST_DRAIN) || (state == ST_GRANT);

  // The board-level halt is passed straight through; the arbiter can only add a hold.
  assign cpu_n_halt = ext_n_halt && !arb_hold;

  // Read data is live from testmem in the rvalid cycle, then held until the next read.
  assign ld_rvalid = rd_pend;
  assign ld_rdata  = rd_pend ? mem_rdata : rdata_hold;

  // Shared timer for the pipeline-drain and CPU run windows.
  io_mem_arbiter_down_counter #(
    .W(CNT_W)
  ) u_phase_cnt (
    .clk      (clk),
    .n_reset  (n_reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // Next-state logic, phase-timer control and burst counting.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    burst_next = burst_cnt;
    cnt_load   = 1'b0;
    cnt_val    = DRAIN_LOAD;
    cnt_dec    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (ld_req) begin
          state_next = ST_DRAIN;
          cnt_load   = 1'b1;
          cnt_val    = DRAIN_LOAD;
        end
      end
      ST_DRAIN: begin
        // A CPU write still in flight pauses the drain for that cycle.
        if (!ld_req) begin
          state_next = ST_IDLE;
        end else if (!cpu_wren) begin
          if (cnt_zero) state_next = ST_GRANT;
          else          cnt_dec    = 1'b1;
        end
      end
      ST_GRANT: begin
        if (!ld_req || (ld_acc && burst_cnt == BURST_LAST)) begin
          state_next = ST_COOL;
          burst_next = '0;
          cnt_load   = 1'b1;
          cnt_val    = COOL_LOAD;
        end else if (ld_acc) begin
          burst_next = burst_cnt + CNT_W'(1);
        end
      end
      ST_COOL: begin
        // Loader requests wait here so the CPU is guaranteed its run window.
        if (cnt_zero) state_next = ST_IDLE;
        else          cnt_dec    = 1'b1;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State, grant, read-return and sticky conflict registers.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state      <= ST_IDLE;
      burst_cnt  <= '0;
      ld_gnt     <= 1'b0;
      rd_pend    <= 1'b0;
      rdata_hold <= '0;
      conflict   <= 1'b0;
    end else begin
      state     <= state_next;
      burst_cnt <= burst_next;
      ld_gnt    <= (state_next == ST_GRANT);
      rd_pend   <= rd_acc;
      if (rd_pend)
        rdata_hold <= mem_rdata;
      if (state == ST_GRANT && cpu_wren)
        conflict <= 1'b1;
    end
  end

  // Memory port mux; a CPU write arriving while the loader owns the memory is dropped.
  always_comb begin
    mem_wren  = cpu_wren;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    if (state == ST_GRANT) begin
      mem_wren  = ld_req && ld_stb && ld_we;
      mem_addr  = ld_addr;
      mem_wdata = ld_wdata;
    end
  end

endmodule

// File: tb/tb_io_mem_arbiter.sv
// Self-checking bench for io_mem_arbiter: testmem model, read-data scoreboard,
// table-driven loader accesses and hand-written sequences for the timing corners.
module tb_io_mem_arbiter;

  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 8;
  localparam int HALT_LAT  = 3;
  localparam int MAX_BURST = 16;
  localparam int CPU_MIN   = 4;

  logic              clk = 1'b0;
  logic              n_reset;
  logic              ext_n_halt;
  logic              cpu_n_halt;
  logic              cpu_wren;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              ld_req;
  logic              ld_gnt;
  logic              ld_stb;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic [DATA_W-1:0] ld_rdata;
  logic              ld_rvalid;
  logic              conflict;
  logic              mem_wren;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic [DATA_W-1:0] testmem [256];
  logic [DATA_W-1:0] sb_q [$];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] exp_rdata;
  } vec_t;

  vec_t vecs [7];

  io_mem_arbiter #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .HALT_LAT  (HALT_LAT),
    .MAX_BURST (MAX_BURST),
    .CPU_MIN   (CPU_MIN)
  ) dut (
    .clk        (clk),
    .n_reset    (n_reset),
    .ext_n_halt (ext_n_halt),
    .cpu_n_halt (cpu_n_halt),
    .cpu_wren   (cpu_wren),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .ld_req     (ld_req),
    .ld_gnt     (ld_gnt),
    .ld_stb     (ld_stb),
    .ld_we      (ld_we),
    .ld_addr    (ld_addr),
    .ld_wdata   (ld_wdata),
    .ld_rdata   (ld_rdata),
    .ld_rvalid  (ld_rvalid),
    .conflict   (conflict),
    .mem_wren   (mem_wren),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] init_val(input logic [ADDR_W-1:0] a);
    return a ^ 8'hC3;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // testmem: synchronous write, one-cycle read latency, known pattern while in reset.
  always @(posedge clk) begin
    if (!n_reset) begin
      for (int i = 0; i < 256; i++) testmem[i] <= init_val(8'(i));
      mem_rdata <= '0;
    end else begin
      if (mem_wren) testmem[mem_addr] <= mem_wdata;
      mem_rdata <= testmem[mem_addr];
    end
  end

  // Scoreboard: each rvalid pulse must match the oldest expected read.
  always @(negedge clk) begin
    if (n_reset && ld_rvalid) begin
      if (sb_q.size() == 0) begin
        check("rvalid_unexpected", 32'(ld_rvalid), 32'(0));
      end else begin
        check("rdata", 32'(ld_rdata), 32'(sb_q.pop_front()));
      end
    end
  end

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Counts edges from the ld_req drive point until ld_gnt; optionally holds
  // cpu_wren for the first wren_cycles DRAIN edges.
  task automatic wait_grant(input int wren_cycles, output int n);
    n = 0;
    while (n < 60) begin
      @(posedge clk);
      n++;
      #1;
      cpu_wren = (n <= wren_cycles);
      if (ld_gnt) break;
    end
    cpu_wren = 1'b0;
  endtask

  int n;
  int halt_hi;
  int gnt_seen;
  logic [DATA_W-1:0] old20;

  initial begin
    vecs[0] = '{we: 1'b1, addr: 8'h11, wdata: 8'hA5, exp_rdata: 8'h00};
    vecs[1] = '{we: 1'b1, addr: 8'h12, wdata: 8'h3C, exp_rdata: 8'h00};
    vecs[2] = '{we: 1'b0, addr: 8'h11, wdata: 8'h00, exp_rdata: 8'hA5};
    vecs[3] = '{we: 1'b0, addr: 8'h12, wdata: 8'h00, exp_rdata: 8'h3C};
    vecs[4] = '{we: 1'b1, addr: 8'h10, wdata: 8'hFF, exp_rdata: 8'h00};
    vecs[5] = '{we: 1'b0, addr: 8'h10, wdata: 8'h00, exp_rdata: 8'hFF};
    vecs[6] = '{we: 1'b0, addr: 8'h30, wdata: 8'h00, exp_rdata: 8'hF3};

    n_reset = 1'b0; ext_n_halt = 1'b1;
    cpu_wren = 1'b0; cpu_addr = 8'hF0; cpu_wdata = 8'h99;
    ld_req = 1'b0; ld_stb = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_wdata = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_gnt", 32'(ld_gnt), 32'(0));
    check("rst_rvalid", 32'(ld_rvalid), 32'(0));
    check("rst_rdata", 32'(ld_rdata), 32'(0));
    check("rst_conflict", 32'(conflict), 32'(0));
    check("rst_n_halt", 32'(cpu_n_halt), 32'(1));
    ext_n_halt = 1'b0;
    #1 check("ext_halt_pass", 32'(cpu_n_halt), 32'(0));
    ext_n_halt = 1'b1;
    @(negedge clk) n_reset = 1'b1;
    idle_cycles(2);

    // Grant latency: halt the cycle after ld_req, grant HALT_LAT+1 edges after it.
    ld_req = 1'b1;
    @(negedge clk) check("halt_before_edge", 32'(cpu_n_halt), 32'(1));
    @(posedge clk) #1;
    check("halt_after_req", 32'(cpu_n_halt), 32'(0));
    check("gnt_in_drain", 32'(ld_gnt), 32'(0));
    wait_grant(0, n);
    check("grant_latency", 32'(n + 1), 32'(HALT_LAT + 1));

    // Loader write 0x5A to 0x10, then read it back.
    ld_stb = 1'b1; ld_we = 1'b1; ld_addr = 8'h10; ld_wdata = 8'h5A;
    @(negedge clk);
    check("wr_mem_wren", 32'(mem_wren), 32'(1));
    check("wr_mem_addr", 32'(mem_addr), 32'(8'h10));
    @(posedge clk) #1;
    check("testmem_10", 32'(testmem[8'h10]), 32'(8'h5A));
    ld_we = 1'b0;
    sb_q.push_back(8'h5A);
    @(negedge clk) check("rvalid_not_early", 32'(ld_rvalid), 32'(0));
    @(posedge clk) #1;
    ld_stb = 1'b0;
    @(negedge clk);
    check("rvalid_pulse", 32'(ld_rvalid), 32'(1));
    check("rdata_5a", 32'(ld_rdata), 32'(8'h5A));
    @(posedge clk) #1;
    @(negedge clk);
    check("rvalid_single", 32'(ld_rvalid), 32'(0));
    check("rdata_hold", 32'(ld_rdata), 32'(8'h5A));
    @(posedge clk) #1;

    // Table-driven back-to-back loader accesses.
    for (int i = 0; i < 7; i++) begin
      ld_stb = 1'b1; ld_we = vecs[i].we; ld_addr = vecs[i].addr; ld_wdata = vecs[i].wdata;
      if (!vecs[i].we) sb_q.push_back(vecs[i].exp_rdata);
      @(negedge clk);
      check("vec_mem_wren", 32'(mem_wren), 32'(vecs[i].we));
      check("vec_mem_addr", 32'(mem_addr), 32'(vecs[i].addr));
      @(posedge clk) #1;
    end
    ld_stb = 1'b0;
    idle_cycles(2);

    // Release by dropping ld_req: grant falls the next cycle.
    ld_req = 1'b0;
    @(posedge clk) #1;
    check("release_gnt", 32'(ld_gnt), 32'(0));
    check("release_n_halt", 32'(cpu_n_halt), 32'(1));
    idle_cycles(8);

    // CPU write in flight extends DRAIN one cycle per cycle.
    ld_req = 1'b1;
    wait_grant(3, n);
    check("drain_extend", 32'(n), 32'(HALT_LAT + 1 + 3));
    ld_req = 1'b0;
    idle_cycles(8);

    // ld_req dropped during DRAIN: back to IDLE, no grant.
    ld_req = 1'b1;
    @(posedge clk) #1;
    check("drop_halted", 32'(cpu_n_halt), 32'(0));
    ld_req = 1'b0;
    @(posedge clk) #1;
    check("drop_n_halt", 32'(cpu_n_halt), 32'(1));
    gnt_seen = 0;
    repeat (10) begin
      @(negedge clk);
      gnt_seen += int'(ld_gnt);
    end
    check("drop_no_gnt", 32'(gnt_seen), 32'(0));
    @(posedge clk) #1;

    // Burst limit: 20 strobes, only MAX_BURST performed, then CPU window and re-grant.
    ld_req = 1'b1;
    wait_grant(0, n);
    halt_hi = 0;
    for (int i = 0; i < 20; i++) begin
      ld_stb = 1'b1; ld_we = 1'b1; ld_addr = 8'(8'h40 + i); ld_wdata = 8'(i + 1);
      @(negedge clk);
      check("burst_gnt", 32'(ld_gnt), 32'(i < MAX_BURST));
      halt_hi += int'(cpu_n_halt);
      @(posedge clk) #1;
    end
    ld_stb = 1'b0;
    for (int k = 0; k < 40 && !ld_gnt; k++) begin
      @(negedge clk);
      halt_hi += int'(cpu_n_halt);
    end
    // CPU runs through all CPU_MIN COOL cycles plus the IDLE cycle before the new DRAIN.
    check("cpu_window", 32'(halt_hi), 32'(CPU_MIN + 1));
    check("regrant", 32'(ld_gnt), 32'(1));
    @(posedge clk) #1;
    for (int i = 0; i < 20; i++) begin
      check("burst_mem", 32'(testmem[8'h40 + i]),
            32'((i < MAX_BURST) ? 8'(i + 1) : init_val(8'(8'h40 + i))));
    end
    check("conflict_clear", 32'(conflict), 32'(0));

    // CPU write forced during GRANT is dropped and flags conflict.
    old20 = testmem[8'h20];
    cpu_wren = 1'b1; cpu_addr = 8'h20; cpu_wdata = 8'h77;
    ld_stb = 1'b1; ld_we = 1'b1; ld_addr = 8'h21; ld_wdata = 8'h44;
    @(negedge clk);
    check("cf_mem_wren", 32'(mem_wren), 32'(1));
    check("cf_mem_addr", 32'(mem_addr), 32'(8'h21));
    check("cf_mem_wdata", 32'(mem_wdata), 32'(8'h44));
    @(posedge clk) #1;
    ld_stb = 1'b0;
    @(negedge clk) check("cf_no_cpu_wren", 32'(mem_wren), 32'(0));
    @(posedge clk) #1;
    cpu_wren = 1'b0;
    idle_cycles(2);
    check("cf_mem20", 32'(testmem[8'h20]), 32'(old20));
    check("cf_mem21", 32'(testmem[8'h21]), 32'(8'h44));
    check("cf_sticky", 32'(conflict), 32'(1));

    // Asynchronous reset in the middle of GRANT.
    check("pre_rst_gnt", 32'(ld_gnt), 32'(1));
    #2 n_reset = 1'b0;
    #1;
    check("arst_gnt", 32'(ld_gnt), 32'(0));
    check("arst_n_halt", 32'(cpu_n_halt), 32'(1));
    check("arst_conflict", 32'(conflict), 32'(0));
    ext_n_halt = 1'b0;
    #1 check("arst_ext_halt", 32'(cpu_n_halt), 32'(0));
    ext_n_halt = 1'b1;
    ld_req = 1'b0;
    @(negedge clk) n_reset = 1'b1;
    idle_cycles(3);
    check("post_rst_gnt", 32'(ld_gnt), 32'(0));
    check("sb_empty", 32'(sb_q.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
